// File: rtl/iob_eth_tx_sched.sv
// iob_eth_tx_sched: round-robin scheduler sharing one Ethernet TX engine between N_REQ frame producers,
// with start timeout, inter-frame gap and per-requester done/err pulses.
module iob_eth_tx_sched #(
  parameter int N_REQ      = 2,
  parameter int NBYTES_W   = 16,
  parameter int SEL_W      = 1,
  parameter int IFG_CYCLES = 12,
  parameter int START_TO   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*NBYTES_W-1:0] req_nbytes,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic                      tx_send,
  output logic [NBYTES_W-1:0]       tx_nbytes,
  output logic [SEL_W-1:0]          tx_buf_sel,
  input  logic                      tx_ready,
  output logic                      busy
);
  localparam int CNT_MAX = IFG_CYCLES > START_TO ? IFG_CYCLES : START_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  state_t state, state_d;
  logic [SEL_W-1:0] ptr, win;
  logic [SEL_W:0] off, sum;
  logic [N_REQ-1:0] rot;
  logic [NBYTES_W-1:0] win_nbytes;
  logic [CNT_W-1:0] cnt;
  logic found, nz, start, to_err, fin;
  // rotate requests so the search always begins at the pointer, then map the offset back
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    found = |rot;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = (SEL_W+1)'(i);
    sum = {1'b0, ptr} + off;
    win = (sum >= (SEL_W+1)'(N_REQ)) ? SEL_W'(sum - (SEL_W+1)'(N_REQ)) : sum[SEL_W-1:0];
    win_nbytes = req_nbytes[win*NBYTES_W +: NBYTES_W];
    nz = |win_nbytes;
  end
  always_comb begin
    state_d = state;
    start = 1'b0;
    to_err = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE:
        if (tx_ready && found) begin
          start = 1'b1;
          state_d = nz ? SEND : GAP;
        end
      SEND: state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (!tx_ready) state_d = WAIT_DONE;
        else if (cnt == CNT_W'(START_TO - 1)) begin
          to_err = 1'b1;
          state_d = GAP;
        end
      WAIT_DONE:
        if (tx_ready) begin
          fin = 1'b1;
          state_d = GAP;
        end
      GAP: state_d = (cnt == CNT_W'(IFG_CYCLES - 1)) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt <= '0;
      done <= '0;
      err <= '0;
      tx_send <= 1'b0;
      tx_nbytes <= '0;
      tx_buf_sel <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      tx_send <= start && nz;
      done <= fin ? N_REQ'(1) << tx_buf_sel : '0;
      err <= to_err ? N_REQ'(1) << tx_buf_sel : (start && !nz) ? N_REQ'(1) << win : '0;
      if (start) begin
        ptr <= (win == SEL_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        tx_buf_sel <= win;
        tx_nbytes <= win_nbytes;
        gnt <= nz ? N_REQ'(1) << win : '0;
      end else if (to_err || fin) gnt <= '0;
      cnt <= ((state == WAIT_BUSY && state_d == WAIT_BUSY) || (state == GAP && state_d == GAP)) ? cnt + 1'b1 : '0;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// tb_iob_eth_tx_sched: randomized frames against a queue-based reference model; a negedge monitor
// pops expected tx_send and done/err events and compares content and cycle.
module tb_iob_eth_tx_sched;
  localparam int N = 2, NBW = 16, SW = 1, IFG = 12, STO = 64;
  logic clk = 0, rst_n = 0, tx_ready = 1;
  logic [N-1:0] req = '0;
  logic [N*NBW-1:0] req_nbytes = '0;
  logic [N-1:0] gnt, done, err;
  logic tx_send, busy;
  logic [NBW-1:0] tx_nbytes;
  logic [SW-1:0] tx_buf_sel;
  iob_eth_tx_sched #(.N_REQ(N), .NBYTES_W(NBW), .SEL_W(SW), .IFG_CYCLES(IFG), .START_TO(STO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_nbytes(req_nbytes), .gnt(gnt), .done(done), .err(err),
    .tx_send(tx_send), .tx_nbytes(tx_nbytes), .tx_buf_sel(tx_buf_sel), .tx_ready(tx_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, passed = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction
  typedef struct {int idx; int nb; int cyc;} send_t;
  typedef struct {logic [2*N-1:0] de; int cyc;} comp_t;
  send_t sq[$];
  comp_t cq[$];
  send_t se;
  comp_t ce;
  always @(negedge clk) begin
    if (rst_n && tx_send) begin
      if (sq.size() == 0) check("send_unexpected", tx_send, 0);
      else begin
        se = sq.pop_front();
        check("send_sel", tx_buf_sel, se.idx);
        check("send_nbytes", tx_nbytes, se.nb);
        check("send_gnt", gnt, 64'(1) << se.idx);
        check("send_cycle", cyc, se.cyc);
      end
    end
    if (rst_n && (done | err) != 0) begin
      check("pulse_onehot", $countones({done, err}), 1);
      if (cq.size() == 0) check("pulse_unexpected", {done, err}, 0);
      else begin
        ce = cq.pop_front();
        check("pulse_vec", {done, err}, ce.de);
        check("pulse_cycle", cyc, ce.cyc);
      end
    end
  end
  logic [N-1:0] pend = '0;
  logic [NBW-1:0] nb [N] = '{default: 0};
  int ptr_m = 0, exp_idle = -1;
  task automatic drive_req();
    req = pend;
    for (int i = 0; i < N; i++) req_nbytes[i*NBW +: NBW] = nb[i];
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", busy, 0);
    else if (exp_idle >= 0) check("idle_cycle", cyc, exp_idle);
  endtask
  function automatic logic [NBW-1:0] pick_nb(input bit rnd, input int nbv);
    return rnd ? (($urandom % 6 == 0) ? '0 : NBW'($urandom_range(1, 1500))) : NBW'(nbv);
  endfunction
  // mode 0: engine transmits (d cycles to go busy, len cycles busy); mode 1: engine never goes busy
  task automatic frame(input logic [N-1:0] add, input int nbv, input bit rnd, input int mode,
                       input int nr, input int d, input int len);
    int t, w, c, k, r;
    wait_idle();
    for (int i = 0; i < N; i++)
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        nb[i] = pick_nb(rnd, nbv);
      end
    if (pend == '0) begin
      r = $urandom_range(0, N - 1);
      pend[r] = 1'b1;
      nb[r] = pick_nb(rnd, nbv);
    end
    drive_req();
    if (nr > 0) begin
      tx_ready = 0;
      repeat (nr) @(negedge clk);
      tx_ready = 1;
    end
    t = cyc;
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && pend[(ptr_m + i) % N]) w = (ptr_m + i) % N;
    ptr_m = (w + 1) % N;
    if (nb[w] == 0) begin
      c = t + 1;
      cq.push_back('{de: (2*N)'(1) << w, cyc: c});
    end else begin
      sq.push_back('{idx: w, nb: int'(nb[w]), cyc: t + 1});
      k = 0;
      while (!tx_send && k < 10) begin
        @(negedge clk);
        k++;
      end
      if (!tx_send) check("send_timeout", tx_send, 1);
      if (mode == 0) begin
        repeat (d > 0 ? d : $urandom_range(1, 5)) @(negedge clk);
        tx_ready = 0;
        repeat (len > 0 ? len : $urandom_range(1, 40)) @(negedge clk);
        tx_ready = 1;
        c = cyc + 1;
        cq.push_back('{de: (2*N)'(1) << (w + N), cyc: c});
      end else begin
        c = cyc + STO + 1;
        cq.push_back('{de: (2*N)'(1) << w, cyc: c});
      end
    end
    k = 0;
    while (!(done[w] | err[w]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!(done[w] | err[w])) check("pulse_timeout", done[w] | err[w], 1);
    pend[w] = 1'b0;
    drive_req();
    exp_idle = c + IFG;
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_send", tx_send, 0);
    check("rst_nbytes", tx_nbytes, 0);
    check("rst_sel", tx_buf_sel, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    frame(2'b01, 64, 0, 0, 0, 3, 100);
    for (int i = 0; i < 4; i++) frame(i == 0 ? 2'b11 : 2'b01 << (i % 2 == 0 ? 1 : 0), 46, 0, 0, 0, 0, 0);
    frame(2'b10, 0, 0, 0, 0, 0, 0);
    frame(2'b01, 64, 0, 1, 0, 0, 0);
    frame(2'b01, 64, 0, 0, 4, 0, 0);
    for (int i = 0; i < 40; i++)
      frame(N'($urandom), 0, 1, ($urandom % 10 == 0) ? 1 : 0, ($urandom % 4 == 0) ? $urandom_range(1, 5) : 0, 0, 0);
    // abort a frame mid-transmission; the pointer must restart at 0 afterwards
    wait_idle();
    pend = '0;
    pend[0] = 1'b1;
    nb[0] = 64;
    drive_req();
    sq.push_back('{idx: 0, nb: 64, cyc: cyc + 1});
    k = 0;
    while (!tx_send && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!tx_send) check("abort_send_timeout", tx_send, 1);
    repeat (2) @(negedge clk);
    tx_ready = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_gnt", gnt, 0);
    check("abort_send", tx_send, 0);
    check("abort_busy", busy, 0);
    check("abort_nbytes", tx_nbytes, 0);
    check("abort_sel", tx_buf_sel, 0);
    check("abort_pulses", {done, err}, 0);
    tx_ready = 1;
    pend = '0;
    drive_req();
    ptr_m = 0;
    exp_idle = -1;
    @(negedge clk);
    rst_n = 1;
    frame(2'b11, 46, 0, 0, 0, 0, 0);
    frame(2'b00, 46, 0, 0, 0, 0, 0);
    wait_idle();
    check("send_queue_empty", sq.size(), 0);
    check("pulse_queue_empty", cq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/iob_eth_tx_sched.md
Name: iob_eth_tx_sched

Overview:
Transmit scheduler that shares the single Ethernet TX engine between N_REQ frame producers, e.g. the CPU-side frame buffer and a hardware responder. It grants requesters round-robin and drives the engine's one-cycle send strobe, byte count and buffer select. It tracks engine busy/ready and enforces a minimum idle gap between frames. It reports per-requester completion and error.

Parameters:
N_REQ, 2, number of requesters (2..8)
NBYTES_W, 16, payload byte-count width (matches engine nbytes width)
SEL_W, 1, buffer-select width, equal to ceil(log2(N_REQ)), minimum 1
IFG_CYCLES, 12, idle clk cycles enforced after engine ready returns (>=1)
START_TO, 64, max clk cycles allowed for engine to go busy after send

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester frame request, level, held until done/err
req_nbytes  in  N_REQ*NBYTES_W  payload byte count; requester i uses slice [i*NBYTES_W +: NBYTES_W]
gnt  out  N_REQ  one-hot grant, high from send cycle through completion
done  out  N_REQ  one-cycle pulse: frame for requester i fully transmitted
err  out  N_REQ  one-cycle pulse: frame for requester i rejected or timed out
tx_send  out  1  one-cycle send strobe to TX engine
tx_nbytes  out  NBYTES_W  byte count to engine, registered, stable while gnt!=0
tx_buf_sel  out  SEL_W  index of granted requester's buffer, registered
tx_ready  in  1  engine ready, already synchronised to clk; low = transmitting
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; gnt, done, err, tx_send, tx_nbytes, tx_buf_sel = 0; busy = 0; rr pointer = 0; counters = 0. Reset mid-frame aborts silently: no done/err is emitted, and the engine finishes on its own.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if tx_ready==1 and any req bit is set, arbitrate round-robin. Search starts at the rr pointer; the first set bit wins. After reset the pointer is 0, so index 0 has top priority. Register gnt, tx_buf_sel and tx_nbytes for the winner. Set rr pointer = winner+1, wrapping to 0 after N_REQ-1. If tx_ready==0, wait and do not grant.
- Zero length: if the winner's nbytes==0, do not send. Pulse err[winner] next cycle, gnt stays 0, go to GAP. The rr pointer still advances.
- Otherwise go to SEND. tx_send=1 for exactly that cycle, gnt held. Latency from req rising in IDLE with engine ready to tx_send: 1 clk.
- SEND -> WAIT_BUSY, and the timeout counter loads 0.
- WAIT_BUSY: on tx_ready==0, go to WAIT_DONE. If the counter reaches START_TO-1 with tx_ready still 1, pulse err[gnt idx], clear gnt and go to GAP. No send retry.
- WAIT_DONE: on tx_ready==1, pulse done[gnt idx] for 1 clk, clear gnt and go to GAP. This state has no timeout, because engine length bounds it.
- GAP: count IFG_CYCLES clk cycles, then go to IDLE. A new grant is therefore possible no earlier than IFG_CYCLES+1 clk after done.
- done/err: combinational pulses are forbidden; both are registered. done and err are never high in the same cycle, and only one bit of each is ever set.
- req changes while granted are ignored. A requester that drops req before winning is simply not considered. req_nbytes is sampled only at grant.
- Simultaneous requests: exactly one grant per frame. Fairness: with all N_REQ requesting continuously, each is granted once per N_REQ frames.
- Counter widths: sized for max(IFG_CYCLES, START_TO); no wrap is possible.

Test Plan:
- Single frame: req[0]=1, nbytes=64, engine drops ready 3 clk after send and raises it 100 clk later -> tx_send 1 clk after req, tx_nbytes=64, tx_buf_sel=0, gnt=01, done[0] pulse 1 clk after ready rises; busy returns low 12 clk after done.
- Round-robin: req=11 held, each frame nbytes=46 -> grant order 0,1,0,1. Every tx_send is separated from the previous done by >=13 clk.
- Zero length: req[1]=1, nbytes=0 -> err[1] pulse, no tx_send, gnt stays 0, next grant allowed after the gap.
- Start timeout: tx_ready stuck 1 after send -> err[0] pulse at 64 clk after WAIT_BUSY entry, gnt cleared, done never pulses.
- Engine not ready: tx_ready=0 at IDLE with req[0]=1 -> no grant until tx_ready rises; grant follows 1 clk later.
- Reset mid-frame: rst_n low during WAIT_DONE -> all outputs 0 immediately. After release with req=10, index 1 is served, since the pointer was reset and 0 is not requesting.
